// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler divides the clock into digit slots. The digit index walks
// units -> thousands, and the BCD inputs are captured once per frame on the
// last slot. Commons and segments are registered together, so the font
// never changes while a common is driven low.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100_000,
  parameter int GUARD    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_four,
  input  logic [3:0] i_three,
  input  logic [3:0] i_two,
  input  logic [3:0] i_one,
  input  logic       i_blank_lz,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_font,
  output logic       o_frame_tick
);

  localparam int              CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;   // {thousands, hundreds, tens, units}
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic             tick_q, tick_d;

  logic             slot_tick;
  logic             in_guard;
  logic [3:0]       digit;
  logic             blank;

  // Active-low segment pattern {dp, g..a}; values above 9 show hex glyphs.
  function automatic logic [7:0] seg_font(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = 8'h88;
      4'hB: f = 8'h83;
      4'hC: f = 8'hC6;
      4'hD: f = 8'hA1;
      4'hE: f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

  assign slot_tick = (cnt_q == CNT_MAX);

  // With no guard interval the comparison would be constant, so drop it.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CNT_W:0] GUARD_V = (CNT_W + 1)'(GUARD);
      assign in_guard = ({1'b0, cnt_q} < GUARD_V);
    end
  endgenerate

  // Select the digit for the current slot and decide leading-zero blanking.
  always_comb begin
    digit = snap_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: begin
        digit = snap_q[3:0];
      end
      2'd1: begin
        digit = snap_q[7:4];
        blank = i_blank_lz && (snap_q[15:4] == 12'h000);
      end
      2'd2: begin
        digit = snap_q[11:8];
        blank = i_blank_lz && (snap_q[15:8] == 8'h00);
      end
      default: begin
        digit = snap_q[15:12];
        blank = i_blank_lz && (snap_q[15:12] == 4'h0);
      end
    endcase
  end

  // Next-state: prescaler, slot index, frame snapshot and output pattern.
  always_comb begin
    cnt_d  = slot_tick ? '0 : cnt_q + 1'b1;
    idx_d  = slot_tick ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    tick_d = 1'b0;
    if (slot_tick && (idx_q == 2'd3)) begin
      snap_d = {i_four, i_three, i_two, i_one};
      tick_d = 1'b1;
    end
    com_d  = in_guard ? 4'b1111 : ~(4'b0001 << idx_q);
    font_d = blank ? 8'hFF : seg_font(digit);
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= 16'h0000;
      com_q  <= 4'b1111;
      font_q <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      com_q  <= com_d;
      font_q <= font_d;
      tick_q <= tick_d;
    end
  end

  assign o_fnd_com    = com_q;
  assign o_fnd_font   = font_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: two instances (guard 2 and guard 0) share
// stimulus; every cycle is compared with a cycle-count based display model.
module tb_fnd_scan_controller;

  localparam int S = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] four = 4'h0, three = 4'h0, two = 4'h0, one = 4'h0;
  logic       blank_lz = 1'b0;

  logic [3:0] com_a, com_b;
  logic [7:0] font_a, font_b;
  logic       tick_a, tick_b;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: edges since reset release and the digits on display.
  int         k = 0;
  logic [3:0] disp [4];
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(S), .GUARD(G)) dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_four(four), .i_three(three), .i_two(two), .i_one(one),
    .i_blank_lz(blank_lz),
    .o_fnd_com(com_a), .o_fnd_font(font_a), .o_frame_tick(tick_a)
  );

  fnd_scan_controller #(.SCAN_DIV(S), .GUARD(0)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_four(four), .i_three(three), .i_two(two), .i_one(one),
    .i_blank_lz(blank_lz),
    .o_fnd_com(com_b), .o_fnd_font(font_b), .o_frame_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, k);
  endtask

  function automatic logic [7:0] exp_font(input int slot, input logic blz);
    logic lead;
    case (slot)
      3:       lead = (disp[3] == 0);
      2:       lead = (disp[3] == 0) && (disp[2] == 0);
      1:       lead = (disp[3] == 0) && (disp[2] == 0) && (disp[1] == 0);
      default: lead = 1'b0;
    endcase
    return (blz && lead) ? 8'hFF : glyph[disp[slot]];
  endfunction

  task automatic step();
    int         c, slot;
    logic [3:0] ec_a, ec_b;
    logic [7:0] ef;
    logic       et;
    @(posedge clk);
    c    = k % S;
    slot = (k / S) % 4;
    ec_b = ~(4'b0001 << slot);
    ec_a = (c < G) ? 4'b1111 : ec_b;
    ef   = exp_font(slot, blank_lz);
    et   = (c == S - 1) && (slot == 3);
    if (et) begin
      disp[0] = one;
      disp[1] = two;
      disp[2] = three;
      disp[3] = four;
    end
    k++;
    #1;
    chk("com_a",    {4'h0, com_a}, {4'h0, ec_a});
    chk("font_a",   font_a, ef);
    chk("tick_a",   {7'h0, tick_a}, {7'h0, et});
    chk("com_b",    {4'h0, com_b}, {4'h0, ec_b});
    chk("font_b",   font_b, ef);
    chk("tick_b",   {7'h0, tick_b}, {7'h0, et});
    chk("onehot_b", 8'($countones(~com_b)), 8'd1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_vals();
    chk("rst_com_a",  {4'h0, com_a}, 8'h0F);
    chk("rst_font_a", font_a, 8'hFF);
    chk("rst_tick_a", {7'h0, tick_a}, 8'h00);
    chk("rst_com_b",  {4'h0, com_b}, 8'h0F);
    chk("rst_font_b", font_b, 8'hFF);
    chk("rst_tick_b", {7'h0, tick_b}, 8'h00);
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_vals();
    end
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) disp[i] = 4'h0;
  endtask

  initial begin
    four = 4'd1; three = 4'd2; two = 4'd3; one = 4'd4;
    blank_lz = 1'b0;
    apply_reset();

    // Idle display of the reset snapshot, first frame tick, new frame.
    run(40);
    // Mid-frame input change must not tear the frame in progress.
    four = 4'd9; three = 4'd9; two = 4'd9; one = 4'd9;
    run(24);
    run(32);

    // Leading-zero blanking on and off.
    four = 4'd0; three = 4'd0; two = 4'd5; one = 4'd0;
    blank_lz = 1'b1;
    run(64);
    blank_lz = 1'b0;
    run(32);
    four = 4'd0; three = 4'd0; two = 4'd0; one = 4'd0;
    blank_lz = 1'b1;
    run(64);

    // Hex glyphs.
    four = 4'hA; three = 4'hB; two = 4'hC; one = 4'hF;
    blank_lz = 1'b0;
    run(64);

    // Random inputs and blanking toggles.
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) begin
        four  = 4'($urandom);
        three = 4'($urandom);
        two   = 4'($urandom);
        one   = 4'($urandom);
        if ($urandom_range(0, 1) == 0) four = 4'h0;
        if ($urandom_range(0, 2) == 0) three = 4'h0;
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step();
    end

    // Reset in the middle of the tens slot, then resume at units.
    for (int i = 0; i < 64; i++) begin
      if (((k / S) % 4 == 1) && (k % S == 5)) break;
      step();
    end
    chk("tens_active", {4'h0, com_a}, 8'h0D);
    apply_reset();
    four = 4'd7; three = 4'd6; two = 4'd5; one = 4'd4;
    blank_lz = 1'b0;
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
